// File: rtl/stack_ctrl.sv
// Two-requester stack controller: round-robin arbitration, saturating stack pointer and
// sequencing of a synchronous-read stack RAM. Define STACK_CTRL_WATERMARK_EN for sp_max.
module stack_ctrl #(
    parameter int unsigned BITS   = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_op,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic                  rsp_err,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [BITS-1:0]       mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [BITS-1:0]       sp,
    output logic                  full,
    output logic                  empty,
    output logic [BITS-1:0]       sp_max
);

    localparam logic [BITS-1:0] SpMax = {BITS{1'b1}};
    localparam logic [BITS-1:0] SpOne = BITS'(1);

    typedef enum logic [1:0] {StIdle, StExec, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic                win;
    logic                win_q;
    logic                op_q;
    logic                err_q;
    logic                prio_q;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [BITS-1:0]     sp_q;

    assign full      = (sp_q == SpMax);
    assign empty     = (sp_q == '0);
    assign sp        = sp_q;
    assign rsp_rdata = rdata_q;

    // Sole valid requester wins; a tie goes to the requester holding priority.
    always_comb begin
        win = 1'b0;
        if (req_valid == 2'b10) begin
            win = 1'b1;
        end else if (req_valid == 2'b11) begin
            win = prio_q;
        end
    end

    assign sel_wdata = win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (|req_valid) state_d = StExec;
            StExec: state_d = (!op_q && !empty) ? StWait : StResp;
            StWait: state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= 1'b0;
            op_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            sp_q    <= '0;
            prio_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req_valid) begin
                        win_q   <= win;
                        op_q    <= req_op[win];
                        wdata_q <= sel_wdata;
                    end
                end
                StExec: begin
                    if (op_q) begin
                        err_q <= full;
                        if (!full) sp_q <= sp_q + SpOne;
                    end else begin
                        err_q <= empty;
                        if (!empty) sp_q <= sp_q - SpOne;
                    end
                end
                StWait: rdata_q <= mem_rdata;
                StResp: prio_q <= ~win_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_err   = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            StIdle: if (|req_valid) req_ready[win] = 1'b1;
            StExec: begin
                if (op_q && !full) begin
                    mem_we    = 1'b1;
                    mem_addr  = sp_q;
                    mem_wdata = wdata_q;
                end else if (!op_q && !empty) begin
                    mem_re   = 1'b1;
                    mem_addr = sp_q - SpOne;
                end
            end
            StResp: begin
                rsp_valid[win_q] = 1'b1;
                rsp_err          = err_q;
            end
            default: ;
        endcase
    end

`ifdef STACK_CTRL_WATERMARK_EN
    logic [BITS-1:0] sp_max_q;

    // Follows sp one cycle late; sp never moves on an overflow error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_max_q <= '0;
        end else if (sp_q > sp_max_q) begin
            sp_max_q <= sp_q;
        end
    end

    assign sp_max = sp_max_q;
`else
    assign sp_max = '0;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl (BITS=4): directed steps plus random traffic against a queue model.
module tb_stack_ctrl;

    localparam int BITS   = 4;
    localparam int DATA_W = 8;
    localparam int MAXN   = (1 << BITS) - 1;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_op;
    logic [15:0]       req_wdata;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic              rsp_err;
    logic [7:0]        rsp_rdata;
    logic              mem_we;
    logic              mem_re;
    logic [3:0]        mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic [3:0]        sp;
    logic              full;
    logic              empty;
    logic [3:0]        sp_max;

    stack_ctrl #(.BITS(BITS), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .sp        (sp),
        .full      (full),
        .empty     (empty),
        .sp_max    (sp_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External synchronous-read RAM
    logic [7:0] ram [16];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    int errors = 0;
    int checks = 0;

    // Reference model
    logic [7:0] stk[$];
    logic       prio_m;
    logic [7:0] last_rdata;
    int         sp_max_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] spmax_exp();
`ifdef STACK_CTRL_WATERMARK_EN
        return 32'(sp_max_m);
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        stk.delete();
        prio_m     = 1'b0;
        last_rdata = 8'h00;
        sp_max_m   = 0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic txn(input logic [1:0] v, input logic [1:0] op, input logic [7:0] w0,
                       input logic [7:0] w1);
        int         win;
        int         sp_before;
        logic       is_push;
        logic       err;
        logic [7:0] wd;
        logic [7:0] pd;
        win       = (v == 2'b10) ? 1 : (v == 2'b11) ? int'(prio_m) : 0;
        is_push   = op[win];
        wd        = (win == 1) ? w1 : w0;
        pd        = 8'h00;
        sp_before = stk.size();
        if (is_push) begin
            err = (sp_before == MAXN);
            if (!err) stk.push_back(wd);
        end else begin
            err = (sp_before == 0);
            if (!err) pd = stk.pop_back();
        end

        req_valid = v;
        req_op    = op;
        req_wdata = {w1, w0};
        #1;
        chk("req_ready", 32'(req_ready), 32'(1) << win);

        @(negedge clk);
        req_valid[win] = 1'b0;
        chk("ready_exec", 32'(req_ready), 0);
        chk("mem_we", 32'(mem_we), 32'(is_push && !err));
        chk("mem_re", 32'(mem_re), 32'(!is_push && !err));
        chk("sp_exec", 32'(sp), 32'(sp_before));
        if (!err) chk("mem_addr", 32'(mem_addr), is_push ? sp_before : sp_before - 1);
        if (is_push && !err) chk("mem_wdata", 32'(mem_wdata), 32'(wd));
        chk("rsp_early", 32'(rsp_valid), 0);

        if (!is_push && !err) begin
            @(negedge clk);
            chk("rsp_wait", 32'(rsp_valid), 0);
            chk("strobe_wait", 32'({mem_we, mem_re}), 0);
        end

        @(negedge clk);
        if (!is_push && !err) last_rdata = pd;
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << win);
        chk("rsp_err", 32'(rsp_err), 32'(err));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(last_rdata));
        chk("sp", 32'(sp), 32'(stk.size()));
        chk("full", 32'(full), 32'(stk.size() == MAXN));
        chk("empty", 32'(empty), 32'(stk.size() == 0));
        prio_m = (win == 0);
        if (stk.size() > sp_max_m) sp_max_m = stk.size();

        @(negedge clk);
        chk("rsp_done", 32'(rsp_valid), 0);
        chk("sp_max", 32'(sp_max), spmax_exp());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_op    = 2'b00;
        req_wdata = 16'h0000;
        model_reset();
        #12;
        chk("rst_sp", 32'(sp), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_strobes", 32'({mem_we, mem_re, req_ready, rsp_valid, rsp_err}), 0);
        chk("rst_addr_wdata", 32'({mem_addr, mem_wdata, rsp_rdata}), 0);
        chk("rst_sp_max", 32'(sp_max), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Push A5 from requester 0, pop it back via requester 1, then underflow.
        txn(2'b01, 2'b01, 8'hA5, 8'h00);
        txn(2'b10, 2'b00, 8'h00, 8'h00);
        txn(2'b01, 2'b00, 8'h00, 8'h00);

        // Both push continuously: grants alternate, 16th push overflows.
        for (int i = 0; i < 16; i++) begin
            txn(2'b11, 2'b11, 8'(2 * i), 8'(2 * i + 1));
        end
        chk("full_after_fill", 32'(full), 1);

        // Random traffic, including idle cycles where a stale valid is withdrawn.
        for (int i = 0; i < 150; i++) begin
            logic [1:0] v;
            v = 2'($urandom_range(0, 3));
            if (v == 2'b00) begin
                req_valid = 2'b00;
                #1;
                chk("idle_ready", 32'(req_ready), 0);
                @(negedge clk);
                chk("idle_sp", 32'(sp), 32'(stk.size()));
            end else begin
                txn(v, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            end
        end

        // Asynchronous reset while a pop waits on RAM data.
        req_valid = 2'b00;
        if (stk.size() == 0) txn(2'b01, 2'b01, 8'h3C, 8'h00);
        req_valid = 2'b01;
        req_op    = 2'b00;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sp", 32'(sp), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_rsp", 32'(rsp_valid), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_no_rsp", 32'(rsp_valid), 0);
        end
        txn(2'b10, 2'b10, 8'h00, 8'h5A);
        txn(2'b11, 2'b00, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
